// File: rtl/ysyx_23060061_idu.sv
// Registered RV32I decode stage: one-entry output buffer with valid/ready on both sides,
// control-bundle and immediate generation, illegal detection, flush and a saturating retire count.
module ysyx_23060061_idu #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CNT_W        = 16,
  parameter logic [XLEN-1:0] RESET_PC_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_instType,
  output logic [3:0]       out_aluOp,
  output logic             out_aluAsel,
  output logic             out_aluBsel,
  output logic             out_RegWrite,
  output logic             out_MemRead,
  output logic             out_MemWrite,
  output logic             out_branch,
  output logic             out_jump,
  output logic [2:0]       out_memSize,
  output logic [1:0]       out_WBSel,
  output logic             out_ebreak,
  output logic             out_ecall,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5, T_NONE = 3'd7
  } inst_type_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9,
    ALU_PASSB = 4'd10, ALU_ADDCLR = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    inst_type_e      instType;
    alu_op_e         aluOp;
    logic            aSel;
    logic            bSel;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic            jump;
    logic [2:0]      memSize;
    logic [1:0]      wbSel;
    logic            ebreak;
    logic            ecall;
    logic            illegal;
  } bundle_t;

  bundle_t          dec, bundle_q;
  logic             valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      imm32;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic             accept, retire;

  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];

  always_comb begin
    dec      = '0;
    imm32    = '0;
    dec.instType = T_NONE;
    dec.aluOp    = ALU_ADD;
    if (in_inst[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (in_inst[6:0])
        OP_R: begin
          dec.instType = T_R;
          dec.rs1 = in_inst[19:15]; dec.rs2 = in_inst[24:20]; dec.rd = in_inst[11:7];
          dec.regWrite = 1'b1;
          case (f3)
            3'd0: dec.aluOp = f7[5] ? ALU_SUB : ALU_ADD;
            3'd1: dec.aluOp = ALU_SLL;
            3'd2: dec.aluOp = ALU_SLT;
            3'd3: dec.aluOp = ALU_SLTU;
            3'd4: dec.aluOp = ALU_XOR;
            3'd5: dec.aluOp = f7[5] ? ALU_SRA : ALU_SRL;
            3'd6: dec.aluOp = ALU_OR;
            default: dec.aluOp = ALU_AND;
          endcase
          if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))))
            dec.illegal = 1'b1;
        end
        OP_IALU: begin
          dec.instType = T_I;
          dec.rs1 = in_inst[19:15]; dec.rd = in_inst[11:7];
          dec.bSel = 1'b1; dec.regWrite = 1'b1;
          imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
          case (f3)
            3'd0: dec.aluOp = ALU_ADD;
            3'd1: dec.aluOp = ALU_SLL;
            3'd2: dec.aluOp = ALU_SLT;
            3'd3: dec.aluOp = ALU_SLTU;
            3'd4: dec.aluOp = ALU_XOR;
            3'd5: dec.aluOp = f7[5] ? ALU_SRA : ALU_SRL;
            3'd6: dec.aluOp = ALU_OR;
            default: dec.aluOp = ALU_AND;
          endcase
          if ((f3 == 3'd1 && f7 != 7'b0000000) ||
              (f3 == 3'd5 && f7 != 7'b0000000 && f7 != 7'b0100000))
            dec.illegal = 1'b1;
        end
        OP_LOAD: begin
          dec.instType = T_I;
          dec.rs1 = in_inst[19:15]; dec.rd = in_inst[11:7];
          dec.bSel = 1'b1; dec.regWrite = 1'b1; dec.memRead = 1'b1;
          dec.wbSel = 2'b10; dec.memSize = f3;
          imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
          if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) dec.illegal = 1'b1;
        end
        OP_STORE: begin
          dec.instType = T_S;
          dec.rs1 = in_inst[19:15]; dec.rs2 = in_inst[24:20];
          dec.bSel = 1'b1; dec.memWrite = 1'b1; dec.memSize = f3;
          imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
          if (f3 > 3'd2) dec.illegal = 1'b1;
        end
        OP_BRANCH: begin
          dec.instType = T_B;
          dec.rs1 = in_inst[19:15]; dec.rs2 = in_inst[24:20];
          dec.branch = 1'b1;
          dec.aluOp = (f3[2:1] == 2'b00) ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
          imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
          if (f3 == 3'd2 || f3 == 3'd3) dec.illegal = 1'b1;
        end
        OP_LUI, OP_AUIPC: begin
          dec.instType = T_U;
          dec.rd = in_inst[11:7];
          dec.bSel = 1'b1; dec.regWrite = 1'b1;
          dec.aSel  = (in_inst[6:0] == OP_AUIPC);
          dec.aluOp = (in_inst[6:0] == OP_AUIPC) ? ALU_ADD : ALU_PASSB;
          imm32 = {in_inst[31:12], 12'b0};
        end
        OP_JAL: begin
          dec.instType = T_J;
          dec.rd = in_inst[11:7];
          dec.aSel = 1'b1; dec.bSel = 1'b1; dec.jump = 1'b1; dec.regWrite = 1'b1;
          dec.wbSel = 2'b01;
          imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        end
        OP_JALR: begin
          dec.instType = T_I;
          dec.rs1 = in_inst[19:15]; dec.rd = in_inst[11:7];
          dec.bSel = 1'b1; dec.jump = 1'b1; dec.regWrite = 1'b1;
          dec.aluOp = ALU_ADDCLR; dec.wbSel = 2'b01;
          imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
          if (f3 != 3'd0) dec.illegal = 1'b1;
        end
        OP_SYSTEM: begin
          if (in_inst == 32'h0010_0073)      dec.ebreak  = 1'b1;
          else if (in_inst == 32'h0000_0073) dec.ecall   = 1'b1;
          else                               dec.illegal = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    dec.imm = XLEN'($signed(imm32));
    if (dec.illegal || dec.ebreak || dec.ecall) begin
      dec.regWrite = 1'b0; dec.memRead = 1'b0; dec.memWrite = 1'b0;
      dec.branch   = 1'b0; dec.jump    = 1'b0;
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = valid_q && out_ready && !flush;

  // pc is held across bubbles; the rest of the bundle is zeroed whenever out_valid drops
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= RESET_PC_VAL;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (flush) begin
        valid_q  <= 1'b0;
        bundle_q <= '0;
      end else if (accept) begin
        valid_q  <= 1'b1;
        pc_q     <= in_pc;
        bundle_q <= dec;
      end else if (out_ready) begin
        valid_q  <= 1'b0;
        bundle_q <= '0;
      end
      if (retire && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_imm      = bundle_q.imm;
  assign out_rs1      = bundle_q.rs1;
  assign out_rs2      = bundle_q.rs2;
  assign out_rd       = bundle_q.rd;
  assign out_instType = bundle_q.instType;
  assign out_aluOp    = bundle_q.aluOp;
  assign out_aluAsel  = bundle_q.aSel;
  assign out_aluBsel  = bundle_q.bSel;
  assign out_RegWrite = bundle_q.regWrite;
  assign out_MemRead  = bundle_q.memRead;
  assign out_MemWrite = bundle_q.memWrite;
  assign out_branch   = bundle_q.branch;
  assign out_jump     = bundle_q.jump;
  assign out_memSize  = bundle_q.memSize;
  assign out_WBSel    = bundle_q.wbSel;
  assign out_ebreak   = bundle_q.ebreak;
  assign out_ecall    = bundle_q.ecall;
  assign out_illegal  = bundle_q.illegal;
  assign dec_count    = cnt_q;

endmodule

// File: tb/tb_ysyx_23060061_idu.sv
// Directed bench for the decode stage: a default instance plus a CNT_W=2 instance sharing stimulus.
module tb_ysyx_23060061_idu;
  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, aSel, bSel, regWr, memRd, memWr, br, jmp, ebrk, ecl, ill;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  iType, memSize;
  logic [3:0]  aluOp;
  logic [1:0]  wbSel;
  logic [15:0] cnt;

  logic        in_ready2, out_valid2, aSel2, bSel2, regWr2, memRd2, memWr2, br2, jmp2, ebrk2, ecl2, ill2;
  logic [31:0] out_pc2, out_imm2;
  logic [4:0]  rs1_2, rs2_2, rd_2;
  logic [2:0]  iType2, memSize2;
  logic [3:0]  aluOp2;
  logic [1:0]  wbSel2;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060061_idu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1(rs1), .out_rs2(rs2), .out_rd(rd),
    .out_instType(iType), .out_aluOp(aluOp), .out_aluAsel(aSel), .out_aluBsel(bSel),
    .out_RegWrite(regWr), .out_MemRead(memRd), .out_MemWrite(memWr), .out_branch(br),
    .out_jump(jmp), .out_memSize(memSize), .out_WBSel(wbSel), .out_ebreak(ebrk),
    .out_ecall(ecl), .out_illegal(ill), .dec_count(cnt)
  );

  ysyx_23060061_idu #(.XLEN(32), .CNT_W(2), .RESET_PC_VAL(32'h0000_0100)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
    .out_pc(out_pc2), .out_imm(out_imm2), .out_rs1(rs1_2), .out_rs2(rs2_2), .out_rd(rd_2),
    .out_instType(iType2), .out_aluOp(aluOp2), .out_aluAsel(aSel2), .out_aluBsel(bSel2),
    .out_RegWrite(regWr2), .out_MemRead(memRd2), .out_MemWrite(memWr2), .out_branch(br2),
    .out_jump(jmp2), .out_memSize(memSize2), .out_WBSel(wbSel2), .out_ebreak(ebrk2),
    .out_ecall(ecl2), .out_illegal(ill2), .dec_count(cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_pc2", out_pc2, 32'h100);
    chk("rst_imm", out_imm, 0);
    chk("rst_regwr", regWr, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    rst = 1'b0; out_ready = 1'b1;
    drive(32'h0050_0093, 32'h8000_0000);           // addi x1,x0,5
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_pc", out_pc, 32'h8000_0000);
    chk("addi_rd", rd, 1);
    chk("addi_rs1", rs1, 0);
    chk("addi_imm", out_imm, 5);
    chk("addi_regwr", regWr, 1);
    chk("addi_bsel", bSel, 1);
    chk("addi_aluop", aluOp, 0);
    chk("addi_type", iType, 1);
    chk("addi_cnt", cnt, 0);

    drive(32'h1234_52B7, 32'h8000_0004);           // lui x5,0x12345
    chk("lui_in_ready", in_ready, 1);
    tick();
    chk("lui_cnt", cnt, 1);
    chk("lui_valid", out_valid, 1);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_aluop", aluOp, 10);
    chk("lui_rd", rd, 5);
    chk("lui_type", iType, 4);

    drive(32'h0020_A423, 32'h8000_0008);           // sw x2,8(x1)
    chk("sw_in_ready", in_ready, 1);
    tick();
    chk("sw_cnt", cnt, 2);
    chk("sw_pc", out_pc, 32'h8000_0008);
    chk("sw_imm", out_imm, 8);
    chk("sw_rs1", rs1, 1);
    chk("sw_rs2", rs2, 2);
    chk("sw_memwr", memWr, 1);
    chk("sw_regwr", regWr, 0);
    chk("sw_memsize", memSize, 2);
    chk("sw_type", iType, 2);

    out_ready = 1'b0;
    drive(32'hFFF0_8113, 32'h8000_000C);           // addi x2,x1,-1
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 32'h8000_0008);
      chk("stall_imm", out_imm, 8);
      chk("stall_memwr", memWr, 1);
      chk("stall_cnt", cnt, 2);
    end
    out_ready = 1'b1;
    tick();
    chk("rel_pc", out_pc, 32'h8000_000C);
    chk("rel_imm", out_imm, 32'hFFFF_FFFF);
    chk("rel_rd", rd, 2);
    chk("rel_rs1", rs1, 1);
    chk("rel_cnt", cnt, 3);
    chk("rel_cnt2", cnt2, 3);

    drive(32'h0010_0073, 32'h8000_0010);           // ebreak
    tick();
    chk("ebreak_flag", ebrk, 1);
    chk("ebreak_ill", ill, 0);
    chk("ebreak_regwr", regWr, 0);
    chk("ebreak_type", iType, 7);
    chk("cnt_4", cnt, 4);
    chk("cnt2_sat", cnt2, 3);

    drive(32'hFFFF_FFFF, 32'h8000_0014);
    tick();
    chk("ones_ill", ill, 1);
    chk("ones_regwr", regWr, 0);

    drive(32'h0000_A0E3, 32'h8000_0018);           // branch funct3=2
    tick();
    chk("bf3_ill", ill, 1);
    chk("bf3_regwr", regWr, 0);
    chk("bf3_branch", br, 0);
    chk("cnt_6", cnt, 6);

    drive(32'h0020_8463, 32'h8000_001C);           // beq x1,x2,8
    tick();
    chk("beq_branch", br, 1);
    chk("beq_imm", out_imm, 8);
    chk("beq_aluop", aluOp, 1);
    chk("beq_type", iType, 3);
    chk("beq_ill", ill, 0);

    drive(32'h0100_00EF, 32'h8000_0020);           // jal x1,16
    tick();
    chk("jal_jump", jmp, 1);
    chk("jal_wbsel", wbSel, 1);
    chk("jal_asel", aSel, 1);
    chk("jal_imm", out_imm, 16);
    chk("jal_type", iType, 5);
    chk("jal_regwr", regWr, 1);
    chk("cnt_8", cnt, 8);

    out_ready = 1'b0;
    drive(32'h0050_0093, 32'h8000_0024);
    tick();
    chk("pre_flush_pc", out_pc, 32'h8000_0020);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", cnt, 8);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_flush_valid", out_valid, 0);
    chk("post_flush_imm", out_imm, 0);
    chk("post_flush_cnt", cnt, 8);

    drive(32'h0050_0093, 32'h8000_0028);
    tick();
    out_ready = 1'b0;
    tick();
    chk("hold_valid", out_valid, 1);
    chk("hold_valid2", out_valid2, 1);
    rst = 1'b1;
    tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_pc", out_pc, 0);
    chk("mrst_cnt", cnt, 0);
    chk("mrst_imm", out_imm, 0);
    chk("mrst_valid2", out_valid2, 0);
    chk("mrst_pc2", out_pc2, 32'h100);
    chk("mrst_cnt2", cnt2, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_23060061_idu.md
Name: ysyx_23060061_idu

Overview:
Registered instruction-decode stage between IFU and EXU with valid/ready handshakes on both sides. It decodes the full RV32I base set plus ebreak/ecall into a control bundle and generates the sign-extended immediate. It flags illegal encodings, supports pipeline flush, and keeps a saturating count of retired-from-decode instructions. It supersedes the single-cycle combinational decoder, which covered only a handful of opcodes.

Parameters:
XLEN, 32, datapath width of pc/imm; immediates sign-extend to XLEN.
CNT_W, 16, width of decoded-instruction counter.
RESET_PC_VAL, 0, value out_pc takes on reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IFU beat valid
in_ready  out  1  IDU can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  pc of in_inst
flush  in  1  kill held and incoming beat
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts
out_pc  out  XLEN  registered pc
out_imm  out  XLEN  sign-extended immediate
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_instType  out  3  R=0 I=1 S=2 B=3 U=4 J=5 none=7
out_aluOp  out  4  0 add,1 sub,2 sll,3 slt,4 sltu,5 xor,6 srl,7 sra,8 or,9 and,10 passB,11 add-clr-lsb
out_aluAsel, out_aluBsel  out  1 each  A: 0 rs1/1 pc; B: 0 rs2/1 imm
out_RegWrite, out_MemRead, out_MemWrite, out_branch, out_jump  out  1 each
out_memSize  out  3  funct3 of load/store
out_WBSel  out  2  00 alu, 01 pc+4, 10 mem
out_ebreak, out_ecall, out_illegal  out  1 each
dec_count  out  CNT_W  accepted-by-EXU count

Behaviour:
- One-entry output register; in_ready = !out_valid | out_ready (combinational; no comb path in_valid->out_valid).
- Accept when in_valid & in_ready & !flush: next cycle out_valid=1 and all out_* reflect in_inst/in_pc. Latency 1 cycle.
- Stall: out_valid & !out_ready -> every out_* held bit-stable; no new accept.
- Handoff: out_valid & out_ready with a simultaneous accept -> new bundle replaces old in the same cycle, no bubble.
- Handoff only: out_valid & out_ready, no accept -> out_valid=0 next cycle.
- flush=1: out_valid=0 next cycle; concurrent input beat dropped; flush wins over accept and handoff. The dropped handoff is not counted.
- rst (sync): out_valid=0, out_pc=RESET_PC_VAL, all other out_* = 0, dec_count=0. Reset overrides flush and accept. Mid-stall reset discards the held bundle.
- dec_count +1 on each out_valid & out_ready & !flush. Saturates at all-ones; does not wrap.
- Decode (when out_valid=0, out_* fields except pc are don't-care; implementation drives them 0):
  - op 0110011 R: aluOp from funct3/funct7[5]; sub/sra only when funct7=0100000; other funct7 != 0 -> illegal.
  - op 0010011 I-ALU: slli/srli/srai need funct7 0000000/0100000, else illegal.
  - op 0000011 load: funct3 in {0,1,2,4,5}, else illegal. MemRead=1, WBSel=10, aluOp add, Bsel=1.
  - op 0100011 store: funct3 in {0,1,2}, else illegal. MemWrite=1, RegWrite=0.
  - op 1100011 branch: funct3 2/3 illegal. branch=1, aluOp sub (beq/bne) or slt/sltu.
  - lui: aluOp passB, Bsel=1.
  - auipc: Asel=1, Bsel=1, add.
  - jal: jump=1, Asel=1, Bsel=1, WBSel=01.
  - jalr (funct3 must be 0): jump=1, aluOp add-clr-lsb, WBSel=01.
  - 1110011: 0x00100073 -> ebreak; 0x00000073 -> ecall; anything else illegal.
  - Any other opcode, or inst[1:0] != 11 -> illegal.
  - Illegal/ebreak/ecall force RegWrite=MemRead=MemWrite=branch=jump=0.
- Immediates: I/S/B/U/J per RV spec, sign-extended from bit 31 to XLEN. R-type imm=0.

Test Plan:
- Reset then in_inst=0x00500093 (addi x1,x0,5), pc=0x80000000, out_ready=1 -> 1 cycle later out_valid=1, rd=1, rs1=0, imm=5, RegWrite=1, Bsel=1, aluOp=0, instType=1; dec_count=1 after handoff.
- 0x123452B7 (lui x5) then 0x0020A423 (sw x2,8(x1)) back-to-back -> lui: imm=0x12345000, aluOp=10; sw: imm=8, rs1=1, rs2=2, MemWrite=1, RegWrite=0, memSize=2; no bubble, in_ready stays 1.
- Stall: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, bundle stable all 5 cycles; release -> next inst appears the following cycle.
- 0x00100073 -> ebreak=1; 0xFFFFFFFF and 0x0000A0E3 (beq with funct3=2) -> illegal=1, RegWrite=0.
- flush asserted while stalled with a new beat presented -> out_valid=0 next cycle, beat dropped, dec_count unchanged.
- CNT_W=2: 5 handoffs -> dec_count reads 3 (saturated); rst mid-stall -> out_valid=0, dec_count=0, out_pc=RESET_PC_VAL.
